// File: rtl/line_clear_engine_if.sv
// Bundle between the game FSM / piece-insert logic and the line-clear engine.
// master drives the commands and board writes; slave is the engine.
interface line_clear_engine_if;
  logic         check_i;
  logic         act_i;
  logic         loadpiece_i;
  logic         clearall_i;
  logic         wr_en;
  logic [4:0]   wr_row;
  logic [3:0]   wr_col;
  logic         wr_val;
  logic [4:0]   rd_row;
  logic [9:0]   rd_data;
  logic [199:0] board_out;
  logic [29:0]  clearlineflags;
  logic [9:0]   lines_total;
  logic [3:0]   level;
  logic [19:0]  score;
  logic         award_pulse;

  modport master (
    output check_i, act_i, loadpiece_i, clearall_i, wr_en, wr_row, wr_col, wr_val, rd_row,
    input  rd_data, board_out, clearlineflags, lines_total, level, score, award_pulse
  );

  modport slave (
    input  check_i, act_i, loadpiece_i, clearall_i, wr_en, wr_row, wr_col, wr_val, rd_row,
    output rd_data, board_out, clearlineflags, lines_total, level, score, award_pulse
  );
endinterface

// File: rtl/line_clear_engine.sv
// Line-clear engine: 20x10 playfield, full-row detection, bottom-up row collapse,
// line/level statistics and score award at the end of a clear sequence.
module line_clear_engine (
  input logic                CLK,
  input logic                RESET,
  line_clear_engine_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_AWARD} state_e;

  state_e           r_state, w_state_next;
  logic [19:0][9:0] r_board;
  logic [19:0]      r_flags;
  logic [2:0]       r_clear_cnt;
  logic [9:0]       r_lines;
  logic [3:0]       r_level;
  logic [19:0]      r_score;

  logic [19:0]      w_full, w_shift_full;
  logic [19:0][9:0] w_shift;
  logic [4:0]       w_k;
  logic             w_flags_nz, w_act, w_award, w_wr_ok;
  logic [9:0]       w_lines_inc, w_lines_div;
  logic [3:0]       w_level_next;
  logic [23:0]      w_base, w_sum;
  logic [19:0]      w_score_next;

  // w_k is the bottommost flagged row; rows above it slide down by one.
  always_comb begin
    w_k          = '0;
    w_full       = '0;
    w_shift_full = '0;
    w_shift      = r_board;
    for (int r = 0; r < 20; r++) begin
      w_full[r] = &r_board[r];
      if (r_flags[r]) w_k = 5'(r);
    end
    for (int r = 1; r < 20; r++) begin
      if (5'(r) <= w_k) w_shift[r] = r_board[r-1];
    end
    w_shift[0] = '0;
    for (int r = 0; r < 20; r++) w_shift_full[r] = &w_shift[r];
  end

  assign w_flags_nz   = |r_flags;
  assign w_act        = bus.act_i && w_flags_nz;
  assign w_wr_ok      = bus.wr_en && (bus.wr_row <= 5'd19) && (bus.wr_col <= 4'd9);
  assign w_lines_inc  = (r_lines == 10'd1023) ? r_lines : r_lines + 10'd1;
  assign w_lines_div  = w_lines_inc / 10'd10;
  assign w_level_next = (w_lines_div > 10'd15) ? 4'd15 : w_lines_div[3:0];

  always_comb begin
    case (r_clear_cnt)
      3'd1:    w_base = 24'd40;
      3'd2:    w_base = 24'd100;
      3'd3:    w_base = 24'd300;
      3'd4:    w_base = 24'd1200;
      default: w_base = 24'd0;
    endcase
  end

  assign w_sum        = 24'(r_score) + w_base * (24'(r_level) + 24'd1);
  assign w_score_next = (w_sum > 24'hFFFFF) ? 20'hFFFFF : w_sum[19:0];

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.clearall_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.check_i && !bus.act_i) w_state_next = S_ACTIVE;
        S_ACTIVE: if (bus.loadpiece_i) w_state_next = S_AWARD;
        S_AWARD:  w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_award = 1'b0;
    if (r_state == S_AWARD && RESET && !bus.clearall_i) w_award = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET || bus.clearall_i) begin
      r_board     <= '0;
      r_flags     <= '0;
      r_clear_cnt <= '0;
      r_lines     <= '0;
      r_level     <= '0;
      r_score     <= '0;
    end else begin
      if (bus.act_i) begin
        if (w_act) begin
          r_board     <= w_shift;
          r_flags     <= w_shift_full;
          r_clear_cnt <= (r_clear_cnt == 3'd4) ? 3'd4 : r_clear_cnt + 3'd1;
          r_lines     <= w_lines_inc;
          r_level     <= w_level_next;
        end
      end else if (bus.check_i) begin
        r_flags <= w_full;
        if (r_state == S_IDLE) r_clear_cnt <= '0;
      end else if (w_wr_ok) begin
        r_board[bus.wr_row][bus.wr_col] <= bus.wr_val;
      end
      // Award uses the count and level held before this edge.
      if (w_award) begin
        r_score     <= w_score_next;
        r_clear_cnt <= '0;
      end
    end
  end

  assign bus.rd_data        = (bus.rd_row <= 5'd19) ? r_board[bus.rd_row] : '0;
  assign bus.board_out      = r_board;
  assign bus.clearlineflags = {10'b0, r_flags};
  assign bus.lines_total    = r_lines;
  assign bus.level          = r_level;
  assign bus.score          = r_score;
  assign bus.award_pulse    = w_award;
endmodule

// File: tb/tb_line_clear_engine.sv
// Randomized and directed stimulus against a row-array reference model; expected
// post-edge snapshots are queued by the driver and popped by an independent monitor.
module tb_line_clear_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_clear_engine_if bus ();

  line_clear_engine dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  localparam int Base [5] = '{0, 40, 100, 300, 1200};

  typedef struct {
    logic [199:0] board;
    logic [29:0]  flags;
    logic [9:0]   lines;
    logic [3:0]   level;
    logic [19:0]  score;
    logic         award;
    logic [9:0]   rd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  logic [9:0]  m_board [20];
  logic [19:0] m_flags;
  int          m_cnt, m_lines, m_level, m_score, m_phase;  // phase: 0 idle, 1 active, 2 award

  logic       t_rst, t_chk, t_act, t_lp, t_ca, t_wr, t_val;
  logic [4:0] t_row, t_rd;
  logic [3:0] t_col;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] full_vec();
    logic [19:0] v;
    for (int r = 0; r < 20; r++) v[r] = (m_board[r] == 10'h3FF);
    return v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    bit award;
    int cnt0, lvl0, k;
    if (!t_rst || t_ca) begin
      for (int r = 0; r < 20; r++) m_board[r] = '0;
      m_flags = '0; m_cnt = 0; m_lines = 0; m_level = 0; m_score = 0; m_phase = 0;
      return;
    end
    award = (m_phase == 2);
    cnt0  = m_cnt;
    lvl0  = m_level;
    if (t_act) begin
      if (m_flags != 0) begin
        k = 0;
        for (int r = 0; r < 20; r++) if (m_flags[r]) k = r;
        for (int r = k; r > 0; r--) m_board[r] = m_board[r-1];
        m_board[0] = '0;
        m_flags = full_vec();
        m_cnt   = imin(m_cnt + 1, 4);
        m_lines = imin(m_lines + 1, 1023);
        m_level = imin(m_lines / 10, 15);
      end
    end else if (t_chk) begin
      m_flags = full_vec();
      if (m_phase == 0) m_cnt = 0;
    end else if (t_wr && t_row < 20 && t_col < 10) begin
      m_board[t_row][t_col] = t_val;
    end
    if (award) begin
      m_score = imin(m_score + Base[cnt0] * (lvl0 + 1), 'hFFFFF);
      m_cnt   = 0;
    end
    case (m_phase)
      0:       if (t_chk && !t_act) m_phase = 1;
      1:       if (t_lp) m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  task automatic clear_t();
    t_rst = 1'b1; t_chk = 1'b0; t_act = 1'b0; t_lp = 1'b0; t_ca = 1'b0;
    t_wr = 1'b0; t_val = 1'b0; t_row = '0; t_col = '0;
  endtask

  // One clock: drive the staged inputs, advance the model, queue the expected state.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    t_rd = 5'($urandom_range(0, 31));
    rst_n           = t_rst;
    bus.check_i     = t_chk;
    bus.act_i       = t_act;
    bus.loadpiece_i = t_lp;
    bus.clearall_i  = t_ca;
    bus.wr_en       = t_wr;
    bus.wr_row      = t_row;
    bus.wr_col      = t_col;
    bus.wr_val      = t_val;
    bus.rd_row      = t_rd;
    model_step();
    for (int r = 0; r < 20; r++) e.board[10*r +: 10] = m_board[r];
    e.flags = {10'b0, m_flags};
    e.lines = 10'(m_lines);
    e.level = 4'(m_level);
    e.score = 20'(m_score);
    e.award = (m_phase == 2) && t_rst && !t_ca;
    e.rd    = (t_rd < 20) ? m_board[t_rd] : 10'h0;
    q.push_back(e);
    clear_t();
  endtask

  task automatic wr(input int row, input int col, input bit val);
    t_wr = 1'b1; t_row = 5'(row); t_col = 4'(col); t_val = val;
    cyc();
  endtask

  task automatic fill_row(input int row);
    for (int c = 0; c < 10; c++) wr(row, c, 1'b1);
  endtask

  task automatic do_check();     t_chk = 1'b1; cyc(); endtask
  task automatic do_act();       t_act = 1'b1; cyc(); endtask
  task automatic do_lp();        t_lp  = 1'b1; cyc(); endtask
  task automatic do_clearall();  t_ca  = 1'b1; cyc(); endtask
  task automatic idle();         cyc();               endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Clear n bottom rows from an empty board and collect the award.
  task automatic tetris(input int n);
    for (int r = 20 - n; r < 20; r++) fill_row(r);
    do_check();
    for (int i = 0; i < n; i++) do_act();
    do_lp();
    idle();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("board_out",      bus.board_out,      mon_e.board);
        chk("clearlineflags", 200'(bus.clearlineflags), 200'(mon_e.flags));
        chk("lines_total",    200'(bus.lines_total),    200'(mon_e.lines));
        chk("level",          200'(bus.level),          200'(mon_e.level));
        chk("score",          200'(bus.score),          200'(mon_e.score));
        chk("award_pulse",    200'(bus.award_pulse),    200'(mon_e.award));
        chk("rd_data",        200'(bus.rd_data),        200'(mon_e.rd));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rounds;
    clear_t();
    t_rd = '0;
    rst_n = 1'b0;
    bus.check_i = 1'b0; bus.act_i = 1'b0; bus.loadpiece_i = 1'b0; bus.clearall_i = 1'b0;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_val = 1'b0; bus.rd_row = '0;
    for (int r = 0; r < 20; r++) m_board[r] = '0;
    m_flags = '0; m_cnt = 0; m_lines = 0; m_level = 0; m_score = 0; m_phase = 0;

    t_rst = 1'b0; cyc();
    t_rst = 1'b0; cyc();
    settle();
    chk("reset_score", 200'(bus.score), 200'd0);

    // Single bottom row clear.
    fill_row(19);
    do_check();
    settle();
    chk("one_row_flags", 200'(bus.clearlineflags), 200'h80000);
    do_act();
    settle();
    chk("one_row_lines", 200'(bus.lines_total), 200'd1);
    chk("one_row_flags_after", 200'(bus.clearlineflags), 200'd0);
    chk("one_row_bottom", 200'(bus.board_out[199:190]), 200'd0);

    // Double clear with a partial row above.
    do_clearall();
    fill_row(18);
    fill_row(19);
    for (int c = 0; c < 10; c += 2) wr(17, c, 1'b1);
    do_check();
    do_act();
    do_act();
    do_lp();
    settle();
    chk("double_award_pulse", 200'(bus.award_pulse), 200'd1);
    idle();
    settle();
    chk("double_score", 200'(bus.score), 200'd100);
    chk("double_pulse_gone", 200'(bus.award_pulse), 200'd0);
    chk("double_row19", 200'(bus.board_out[199:190]), 200'h155);
    chk("double_upper_rows", 200'(bus.board_out[189:0]), 200'd0);

    // Zero-line award: pulse with no score change.
    do_check();
    do_lp();
    idle();
    settle();
    chk("zero_award_score", 200'(bus.score), 200'd100);

    // Nine singles then a tetris crossing into level 1.
    do_clearall();
    for (int i = 0; i < 9; i++) tetris(1);
    tetris(4);
    settle();
    chk("tetris_level", 200'(bus.level), 200'd1);
    chk("tetris_lines", 200'(bus.lines_total), 200'd13);
    chk("tetris_score", 200'(bus.score), 200'd2760);

    // Out-of-range writes, empty act, act beating a write.
    do_clearall();
    wr(20, 3, 1'b1);
    wr(5, 10, 1'b1);
    do_act();
    t_act = 1'b1; t_wr = 1'b1; t_row = 5'd5; t_col = 4'd5; t_val = 1'b1; cyc();
    settle();
    chk("ignored_writes", bus.board_out, 200'd0);
    chk("empty_act_lines", 200'(bus.lines_total), 200'd0);

    // Reset plus clearall in the middle of a sequence.
    fill_row(18);
    fill_row(19);
    do_check();
    do_act();
    do_act();
    t_rst = 1'b0; t_ca = 1'b1; cyc();
    settle();
    chk("midseq_reset_lines", 200'(bus.lines_total), 200'd0);
    do_lp();
    settle();
    chk("midseq_no_award", 200'(bus.award_pulse), 200'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      t_rst = ($urandom_range(0, 199) != 0);
      t_ca  = ($urandom_range(0, 149) == 0);
      t_act = ($urandom_range(0, 9) == 0);
      t_chk = ($urandom_range(0, 9) == 0);
      t_lp  = ($urandom_range(0, 15) == 0);
      t_wr  = ($urandom_range(0, 3) != 0);
      t_row = 5'($urandom_range(12, 21));
      t_col = 4'($urandom_range(0, 10));
      t_val = ($urandom_range(0, 7) != 0);
      cyc();
    end

    // Drive lines and score into saturation.
    do_clearall();
    rounds = 0;
    while ((m_lines < 1023 || m_score < 'hFFFFF) && rounds < 400) begin
      tetris(4);
      rounds++;
    end
    settle();
    chk("sat_lines", 200'(bus.lines_total), 200'd1023);
    chk("sat_level", 200'(bus.level), 200'd15);
    chk("sat_score", 200'(bus.score), 200'hFFFFF);

    idle();
    idle();
    settle();
    settle();
    chk("queue_drained", 200'(q.size()), 200'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RESET  in  1  synchronous, active-low reset.
REQ-003 check_i  in  1  SIG_CLEARLINECHECK from game FSM; latch full-row flags.
REQ-004 act_i  in  1  SIG_CLEARLINEACT; remove bottommost flagged row.
REQ-005 loadpiece_i  in  1  SIG_LOADPIECE; ends clear sequence, triggers score award.
REQ-006 clearall_i  in  1  SIG_CLEARALL; wipe board and statistics.
REQ-007 wr_en / wr_row[4:0] / wr_col[3:0] / wr_val  in  1/5/4/1  single-cell board write from piece-insert logic.
REQ-008 rd_row  in  5  combinational row read address.
REQ-009 rd_data  out  10  board row rd_row, bit c = column c; 0 when rd_row>19.
REQ-010 board_out  out  200  full board, bits [10r+9:10r] = row r (row 0 top, row 19 bottom).
REQ-011 clearlineflags  out  30  registered; bit r=1 means row r full; bits [29:20] always 0.
REQ-012 lines_total  out  10  cumulative cleared lines, saturates at 1023.
REQ-013 level  out  4  min(lines_total/10, 15), drives gravity clock.
REQ-014 score  out  20  cumulative score, saturates at 20'hFFFFF.
REQ-015 award_pulse  out  1  one-cycle strobe in cycle score updates.

Function
REQ-016 Board: 20x10 register array; row r full when all 10 bits are 1.
REQ-017 Per-cycle priority: clearall_i > act_i > check_i > wr_en; lower-priority board/flag actions that cycle are dropped.
REQ-018 Write: wr_en with wr_row<=19 and wr_col<=9 sets cell to wr_val next edge; out-of-range writes ignored.
REQ-019 Check: on check_i, clearlineflags <= full-row vector of current board; FSM enters S_ACTIVE, clear_cnt <= 0.
REQ-020 Act: on act_i with flags nonzero, k = highest set flag index; next edge rows k..1 take rows k-1..0, row 0 <= 0, clearlineflags <= full-row vector of post-shift board, clear_cnt += 1 (saturate 4), lines_total += 1.
REQ-021 Act with flags zero: no board, flag, count or statistic change.
REQ-022 Single-cycle latency: flags after an act edge are valid in the very next cycle (game FSM samples them in S_CLEARLINE).
REQ-023 level recomputed in the same edge lines_total changes.
REQ-024 FSM states: S_IDLE, S_ACTIVE, S_AWARD.
REQ-025 S_IDLE -> S_ACTIVE on check_i; S_ACTIVE stays on act_i/check_i (check_i in S_ACTIVE does not reset clear_cnt); S_ACTIVE -> S_AWARD on loadpiece_i; S_AWARD -> S_IDLE unconditionally after one cycle.
REQ-026 loadpiece_i in S_IDLE: ignored, no award.
REQ-027 In S_AWARD: score += base[clear_cnt]*(level+1), base = {0,40,100,300,1200}, level as registered that cycle; award_pulse=1; clear_cnt <= 0.
REQ-028 Award arithmetic at 24 bits minimum; result clamped to 20'hFFFFF.
REQ-029 clear_cnt=0 award: award_pulse still asserted, score unchanged.
REQ-030 clearall_i in any state: board, clearlineflags, clear_cnt, lines_total, level, score <= 0; FSM -> S_IDLE; award_pulse=0.
REQ-031 rd_data and board_out reflect registered board only (no write bypass).

Reset
REQ-032 RESET=0 at an edge: board all 0, clearlineflags=0, lines_total=0, level=0, score=0, clear_cnt=0, award_pulse=0, FSM=S_IDLE.
REQ-033 RESET overrides all inputs, including clearall_i and an in-progress clear sequence; no partial shift or award survives.
REQ-034 Outputs valid first cycle after RESET deasserts.

Verification
REQ-035 Fill row 19 via 10 writes, check_i -> clearlineflags=30'h80000; act_i -> next cycle row 19=0, flags=0, lines_total=1.
REQ-036 Rows 18,19 full, row 17=10'h155: check, act, act, loadpiece -> row 19=10'h155, rows 0-18 zero, award_pulse 1 cycle, score=100.
REQ-037 Preload lines_total=9 via 9 clears, then 4-line clear at level 1 -> level=1 after act, score gains 1200*2=2400.
REQ-038 Score preset near 20'hFFFF0, award 1200 -> score=20'hFFFFF.
REQ-039 wr_en with wr_row=20 or wr_col=10 -> board unchanged; act_i with flags=0 -> no change; act_i+wr_en same cycle -> write dropped.
REQ-040 RESET=0 and clearall_i asserted mid-sequence (S_ACTIVE, clear_cnt=2) -> all outputs 0, FSM=S_IDLE, later loadpiece_i gives no award_pulse.
